// File: rtl/ft2232h_frame_tx_if.sv
// Upstream frame handshake plus FT2232H synchronous-FIFO write bus.
// The master side is the frame source and FIFO; the slave side is the transmitter.
interface ft2232h_frame_tx_if #(
    parameter int FRAME_BITS = 560
);
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  txe;
    logic                  wr;
    logic [7:0]            data_out;

    modport master (
        output frame_data, frame_valid, txe,
        input  frame_ready, wr, data_out
    );

    modport slave (
        input  frame_data, frame_valid, txe,
        output frame_ready, wr, data_out
    );
endinterface

// File: rtl/ft2232h_frame_tx.sv
// Serialises one packed sample frame MSB-first onto the FT2232H 8-bit write bus,
// with optional sync/sequence header and XOR checksum trailer; refused bytes are re-presented.
module ft2232h_frame_tx #(
    parameter int         SAMPLE_WIDTH = 14,
    parameter int         NUM_SAMPLES  = 40,
    parameter bit         HEADER_EN    = 1'b1,
    parameter bit         CHECKSUM_EN  = 1'b1,
    parameter logic [7:0] SYNC0        = 8'hA5,
    parameter logic [7:0] SYNC1        = 8'h5A
) (
    input  logic                     clk,
    input  logic                     rst_n,
    ft2232h_frame_tx_if.slave        bus,
    output logic                     busy,
    output logic                     frame_done,
    output logic [7:0]               seq_num
);
    localparam int FRAME_BITS    = SAMPLE_WIDTH * NUM_SAMPLES;
    localparam int PAYLOAD_BYTES = (FRAME_BITS + 7) / 8;
    localparam int PAY_W         = PAYLOAD_BYTES * 8;
    localparam int PAD_BITS      = PAY_W - FRAME_BITS;
    localparam int HDR_BYTES     = HEADER_EN ? 3 : 0;
    localparam int TOTAL_BYTES   = HDR_BYTES + PAYLOAD_BYTES + (CHECKSUM_EN ? 1 : 0);
    localparam int IDX_W         = $clog2(TOTAL_BYTES + 1);

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                         state;
    logic [IDX_W-1:0]               idx;
    logic [IDX_W-1:0]               nxt_idx;
    logic [PAYLOAD_BYTES-1:0][7:0]  payload_in;
    logic [PAYLOAD_BYTES-1:0][7:0]  shadow;
    logic [7:0]                     cks_in;
    logic [7:0]                     checksum;
    logic [7:0]                     next_byte;
    logic                           accept;

    // Left-justify the frame so a trailing partial byte is zero-padded in its low bits.
    assign payload_in = PAY_W'(bus.frame_data) << PAD_BITS;
    assign nxt_idx    = idx + IDX_W'(1);
    assign accept     = !bus.wr && !bus.txe;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        cks_in = 8'h00;
        for (int k = 0; k < PAYLOAD_BYTES; k++) cks_in = cks_in ^ payload_in[k];
    end

    always_comb begin
        next_byte = shadow[0];
        if (HEADER_EN && nxt_idx == IDX_W'(1)) begin
            next_byte = SYNC1;
        end else if (HEADER_EN && nxt_idx == IDX_W'(2)) begin
            next_byte = seq_num;
        end else if (CHECKSUM_EN && nxt_idx == IDX_W'(TOTAL_BYTES - 1)) begin
            next_byte = checksum;
        end else begin
            for (int k = 0; k < PAYLOAD_BYTES; k++) begin
                if (nxt_idx == IDX_W'(HDR_BYTES + k)) next_byte = shadow[PAYLOAD_BYTES-1-k];
            end
        end
    end

    // NOTE: the shadow frame and its checksum are pure datapath loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.frame_valid) begin
            shadow   <= payload_in;
            checksum <= cks_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            idx             <= '0;
            bus.wr          <= 1'b1;
            bus.data_out    <= 8'h00;
            bus.frame_ready <= 1'b1;
            busy            <= 1'b0;
            frame_done      <= 1'b0;
            seq_num         <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.frame_valid) begin
                        idx             <= '0;
                        bus.data_out    <= HEADER_EN ? SYNC0 : payload_in[PAYLOAD_BYTES-1];
                        bus.frame_ready <= 1'b0;
                        busy            <= 1'b1;
                        state           <= SEND;
                    end
                end
                SEND: begin
                    if (accept) begin
                        if (idx == IDX_W'(TOTAL_BYTES - 1)) begin
                            bus.wr     <= 1'b1;
                            frame_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            idx          <= nxt_idx;
                            bus.data_out <= next_byte;
                            bus.wr       <= 1'b0;
                        end
                    end else begin
                        // Refused or not yet offered: hold the byte, follow TXE# for the next edge.
                        bus.wr <= bus.txe;
                    end
                end
                DONE: begin
                    seq_num         <= seq_num + 8'd1;
                    bus.frame_ready <= 1'b1;
                    busy            <= 1'b0;
                    state           <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
